rate_control_mc: RTL

RATE_CONTROL_MC -- requirements
Module: rate_control_mc

---
 rtl/rate_control_mc.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/rate_control_mc.sv
// rate_control_mc: per-channel token-bucket rate limiters feeding a round-robin
// arbiter that loads a single registered output stream.

module rate_control_mc_ch #(
    parameter int COUNT_WIDTH  = 32,
    parameter int CREDIT_WIDTH = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    enable_i,
    input  logic [COUNT_WIDTH-1:0]  period_i,
    input  logic [CREDIT_WIDTH-1:0] ceil_i,
    input  logic                    xfer_i,
    output logic                    credit_ok_o
);
    logic [COUNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [CREDIT_WIDTH-1:0] credit_q, credit_d, credit_net;
    logic                    unthrottled;

    assign unthrottled = (period_i == '0);
    assign credit_ok_o = unthrottled || (credit_q != '0);

    // A beat leaving this cycle frees room, so the counter keeps running and a
    // saturated single-credit channel still sustains one beat per period.
    assign credit_net = (xfer_i && !unthrottled) ? credit_q - CREDIT_WIDTH'(1) : credit_q;

    always_comb begin
        cnt_d    = cnt_q;
        credit_d = credit_q;
        if (!enable_i) begin
            cnt_d    = '0;
            credit_d = '0;
        end else if (unthrottled) begin
            cnt_d = '0;
        end else if (credit_net < ceil_i) begin
            if (cnt_q >= period_i - COUNT_WIDTH'(1)) begin
                cnt_d    = '0;
                credit_d = credit_net + CREDIT_WIDTH'(1);
            end else begin
                cnt_d    = cnt_q + COUNT_WIDTH'(1);
                credit_d = credit_net;
            end
        end else begin
            cnt_d    = '0;
            credit_d = credit_net;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q    <= '0;
            credit_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            credit_q <= credit_d;
        end
    end
endmodule

module rate_control_mc #(
    parameter int COUNT_WIDTH  = 32,
    parameter int AXIS_WIDTH   = 32,
    parameter int NUM_CH       = 4,
    parameter int CREDIT_WIDTH = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NUM_CH-1:0]             enable_i,
    input  logic [NUM_CH*COUNT_WIDTH-1:0] cycles_per_sample_i,
    input  logic [CREDIT_WIDTH-1:0]       max_credit_i,
    input  logic [NUM_CH*AXIS_WIDTH-1:0]  s_data_i,
    input  logic [NUM_CH-1:0]             s_valid_i,
    output logic [NUM_CH-1:0]             s_ready_o,
    output logic [AXIS_WIDTH-1:0]         m_data_o,
    output logic [$clog2(NUM_CH)-1:0]     m_chan_o,
    output logic                          m_valid_o,
    input  logic                          m_ready_i
);
    localparam int CHW = $clog2(NUM_CH);
    localparam int IW  = CHW + 1;

    logic [NUM_CH-1:0][COUNT_WIDTH-1:0] period_v;
    logic [NUM_CH-1:0][AXIS_WIDTH-1:0]  data_v;
    logic [CREDIT_WIDTH-1:0]            ceil_eff;
    logic [NUM_CH-1:0]                  credit_ok, elig, xfer;
    logic                               loadable, gnt_vld;
    logic [CHW-1:0]                     gnt_idx, ptr_q, ptr_d;
    logic [IW-1:0]                      scan;
    logic                               m_valid_q, m_valid_d;
    logic [AXIS_WIDTH-1:0]              m_data_q, m_data_d;
    logic [CHW-1:0]                     m_chan_q, m_chan_d;

    assign period_v = cycles_per_sample_i;
    assign data_v   = s_data_i;
    assign ceil_eff = (max_credit_i == '0) ? CREDIT_WIDTH'(1) : max_credit_i;
    assign loadable = rst_ni && (!m_valid_q || m_ready_i);
    assign elig     = enable_i & s_valid_i & credit_ok;
    assign xfer     = s_ready_o & s_valid_i;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        rate_control_mc_ch #(
            .COUNT_WIDTH (COUNT_WIDTH),
            .CREDIT_WIDTH(CREDIT_WIDTH)
        ) u_ch (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .enable_i   (enable_i[g]),
            .period_i   (period_v[g]),
            .ceil_i     (ceil_eff),
            .xfer_i     (xfer[g]),
            .credit_ok_o(credit_ok[g])
        );
    end

    // ptr_q is the first channel searched; it moves to one past each winner.
    always_comb begin
        gnt_vld   = 1'b0;
        gnt_idx   = '0;
        scan      = '0;
        s_ready_o = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            scan = IW'(ptr_q) + IW'(k);
            if (scan >= IW'(NUM_CH)) scan = scan - IW'(NUM_CH);
            if (!gnt_vld && loadable && elig[scan[CHW-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = scan[CHW-1:0];
            end
        end
        if (gnt_vld) s_ready_o[gnt_idx] = 1'b1;
    end

    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_chan_d  = m_chan_q;
        ptr_d     = ptr_q;
        if (gnt_vld) begin
            m_valid_d = 1'b1;
            m_data_d  = data_v[gnt_idx];
            m_chan_d  = gnt_idx;
            ptr_d     = (gnt_idx == CHW'(NUM_CH-1)) ? '0 : gnt_idx + CHW'(1);
        end else if (m_ready_i) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_chan_q  <= '0;
            ptr_q     <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_chan_q  <= m_chan_d;
            ptr_q     <= ptr_d;
        end
    end

    assign m_valid_o = m_valid_q;
    assign m_data_o  = m_data_q;
    assign m_chan_o  = m_chan_q;
endmodule
